mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Consumer of EX-stage results in the 5-stage RV32I pipeline.
//  - Accepts one EX result per valid/ready handshake.
//  - Performs the load/store on the data-memory bus (req/gnt, then rvalid).
//  - Aligns and sign/zero-extends load data.
//  - Presents the writeback packet to WB over a valid/ready handshake.
//  - Non-memory ops pass through with one cycle of latency.
// PARAMETERS
//  XLEN     32   datapath width (only 32 supported)
//  REG_AW   5    register-index width
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      reset, asynchronous, active-high
//  ex_valid       in   1      EX packet valid
//  ex_ready       out  1      stage can accept EX packet
//  ex_alu_result  in   32     ALU result / effective address
//  ex_store_data  in   32     rs2 value for stores
//  ex_rd          in   5      destination register
//  ex_reg_write   in   1      packet writes rd
//  ex_mem_read    in   1      load
//  ex_mem_write   in   1      store (mem_read and mem_write never both 1)
//  ex_funct3      in   3      access size/sign (RV32I load/store funct3)
//  dmem_req       out  1      bus request
//  dmem_we        out  1      1 = write
//  dmem_addr      out  32     word address {addr[31:2],2'b00}
//  dmem_be        out  4      byte enables
//  dmem_wdata     out  32     lane-replicated store data
//  dmem_gnt       in   1      request accepted this cycle
//  dmem_rvalid    in   1      response (load data or store ack)
//  dmem_rdata     in   32     load data
//  wb_valid       out  1      WB packet valid
//  wb_ready       in   1      WB accepts packet
//  wb_rd          out  5      destination register
//  wb_reg_write   out  1      write enable (forced 0 on fault)
//  wb_data        out  32     load result or ALU result
//  wb_fault       out  1      misaligned address or illegal funct3
// BEHAVIOUR
//  Reset: all outputs = 0; state = IDLE; packet registers cleared.
//  FSM states: IDLE, REQ, WAIT, OUT.
//   - IDLE: ex_ready = 1. On ex_valid, latch the packet.
//     - mem op, legal: go to REQ.
//     - mem op, fault: go to OUT; wb_fault = 1; no bus access.
//     - non-mem op: go to OUT; wb_data = ex_alu_result.
//   - REQ: dmem_req = 1 with we/addr/be/wdata stable until dmem_gnt.
//     - On gnt, go to WAIT. dmem_req is 0 from the next cycle.
//     - If gnt and rvalid arrive in the same cycle, go straight to OUT.
//   - WAIT: wait for dmem_rvalid, then go to OUT.
//     - Load data is captured and formatted on that edge.
//   - OUT: wb_valid = 1; outputs stay stable until wb_ready.
//     - If wb_ready && ex_valid, accept the next packet in the same cycle.
//     - If wb_ready without ex_valid, go to IDLE.
//   - ex_ready = (state == IDLE) || (state == OUT && wb_ready).
//  Latency:
//   - non-mem op: 1 cycle to wb_valid.
//   - mem op with zero-wait gnt/rvalid: 3 cycles.
//   - Throughput: one packet per cycle for back-to-back non-mem ops.
//  Sizes, with off = addr[1:0]:
//   - SB: be = 1 << off; wdata = {4{sd[7:0]}}.
//   - SH: be = 4'b0011 << off; wdata = {2{sd[15:0]}}; fault if off[0].
//   - SW: be = 4'hF; fault if off != 0.
//   - Loads: byte/half taken from rdata >> (8*off).
//     - LB/LH sign-extend; LBU/LHU zero-extend; LW uses the full word.
//     - Loads drive be for their size, we = 0.
//   - funct3 011/110/111 on a mem op, and store funct3 >= 3: fault.
//  Stores: wb_reg_write = 0; wb_data = 0; WB packet issued after rvalid ack.
//  Fault: wb_reg_write = 0, wb_data = address; fault packet still handshakes.
//  dmem_rvalid outside WAIT/REQ is ignored.
//  Async reset mid-transaction: dmem_req drops immediately; FSM -> IDLE.
//   - A late rvalid from the aborted access is ignored.
// TESTING
//  1. ADD result 0x1234, rd=5, wb_ready=1 -> wb_valid next cycle, wb_data=0x1234.
//  2. LB addr 0x1003, rdata 0x80FF_FF7F -> be=4'b1000, wb_data=0xFFFF_FF80.
//     LBU same access -> wb_data=0x0000_0080.
//  3. SH addr 0x2002, sd=0xABCD, gnt after 3 cycles -> req held 4 cycles,
//     be=4'b1100, wdata=0xABCD_ABCD, wb_reg_write=0.
//  4. LW addr 0x0006 -> no dmem_req; wb_fault=1, wb_reg_write=0, wb_data=6.
//  5. wb_ready=0 for 5 cycles in OUT -> wb outputs stable, ex_ready=0.
//     Then wb_ready=1 with ex_valid=1 -> new packet accepted same cycle.
//  6. rst pulse while in WAIT, rvalid 2 cycles later -> state IDLE, no wb_valid.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 5-stage RV32I pipeline.
//   Takes one EX packet per ex_valid/ex_ready handshake. Performs its load or
//   store on the data-memory bus (req/gnt, then rvalid). Aligns and extends
//   load data. Hands the writeback packet to WB over wb_valid/wb_ready.
//   Non-memory ops reach WB one cycle after they are accepted.
//
// Ports
//   clk, rst                 rising-edge clock, async active-high reset
//   ex_valid / ex_ready      EX handshake
//   ex_alu_result            ALU result or effective address
//   ex_store_data            rs2 value for stores
//   ex_rd, ex_reg_write      destination register and its write enable
//   ex_mem_read/ex_mem_write load / store select
//   ex_funct3                RV32I access size and sign
//   dmem_req/we/addr/be/wdata  bus request side (word address, byte lanes)
//   dmem_gnt                 request accepted this cycle
//   dmem_rvalid/dmem_rdata   response: load data or store acknowledge
//   wb_valid / wb_ready      WB handshake
//   wb_rd, wb_reg_write, wb_data, wb_fault  writeback packet
module mem_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_funct3,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_reg_write,
  output logic [XLEN-1:0]   wb_data,
  output logic              wb_fault
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

  state_t state, state_nx;

  logic              take;
  logic              in_mem;
  logic [1:0]        in_off;
  logic              in_bad_f3;
  logic              in_misalign;
  logic              in_fault;
  logic [3:0]        in_be;
  logic [XLEN-1:0]   in_wdata;

  logic [XLEN-1:0]   pkt_addr;
  logic [3:0]        pkt_be;
  logic [XLEN-1:0]   pkt_wdata;
  logic              pkt_we;
  logic [2:0]        pkt_f3;

  logic              resp;
  logic [XLEN-1:0]   rd_shifted;
  logic [XLEN-1:0]   load_fmt;

  // A new packet is taken when idle, or when the current one leaves this cycle.
  assign take   = ex_valid && ((state == IDLE) || (state == OUT && wb_ready));
  assign in_mem = ex_mem_read | ex_mem_write;
  assign in_off = ex_alu_result[1:0];

  // A bus response counts only while an access is outstanding; a grant and a
  // response in the same REQ cycle complete the access at once.
  assign resp = (state == WAIT && dmem_rvalid) ||
                (state == REQ && dmem_gnt && dmem_rvalid);

  // Decode the incoming packet: legality, byte lanes and lane-replicated data.
  // funct3[1:0] is the size (byte/half/word); funct3[2] marks unsigned loads.
  always_comb begin
    in_bad_f3   = 1'b0;
    in_misalign = 1'b0;
    in_be       = 4'hF;
    in_wdata    = ex_store_data;
    if (ex_mem_write)
      in_bad_f3 = ex_funct3[2] | (ex_funct3[1:0] == 2'b11);
    else
      in_bad_f3 = (ex_funct3 == 3'b011) || (ex_funct3[2:1] == 2'b11);
    case (ex_funct3[1:0])
      2'b00: begin
        in_be    = 4'b0001 << in_off;
        in_wdata = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        in_misalign = in_off[0];
        in_be       = 4'b0011 << in_off;
        in_wdata    = {2{ex_store_data[15:0]}};
      end
      default: begin
        in_misalign = (in_off != 2'b00);
        in_be       = 4'hF;
        in_wdata    = ex_store_data;
      end
    endcase
    in_fault = in_mem && (in_bad_f3 || in_misalign);
  end

  // Move the addressed byte/half down to bit 0, then extend by funct3.
  always_comb begin
    rd_shifted = dmem_rdata >> {pkt_addr[1:0], 3'b000};
    case (pkt_f3)
      3'b000:  load_fmt = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      3'b001:  load_fmt = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      3'b100:  load_fmt = {24'b0, rd_shifted[7:0]};
      3'b101:  load_fmt = {16'b0, rd_shifted[15:0]};
      default: load_fmt = rd_shifted;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic. Legal memory ops go to the bus; everything else
  // (ALU ops and faulting accesses) goes straight to OUT.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (ex_valid) state_nx = (in_mem && !in_fault) ? REQ : OUT;
      REQ:  if (dmem_gnt) state_nx = dmem_rvalid ? OUT : WAIT;
      WAIT: if (dmem_rvalid) state_nx = OUT;
      OUT: begin
        if (wb_ready) begin
          if (ex_valid) state_nx = (in_mem && !in_fault) ? REQ : OUT;
          else          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state. Bus fields are driven only while requesting,
  // and ex_ready stays low while reset is asserted.
  always_comb begin
    ex_ready   = !rst && ((state == IDLE) || (state == OUT && wb_ready));
    dmem_req   = (state == REQ);
    wb_valid   = (state == OUT);
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_be    = 4'h0;
    dmem_wdata = '0;
    if (state == REQ) begin
      dmem_we    = pkt_we;
      dmem_addr  = {pkt_addr[XLEN-1:2], 2'b00};
      dmem_be    = pkt_be;
      dmem_wdata = pkt_we ? pkt_wdata : '0;
    end
  end

  // Packet registers. wb_data starts as the ALU result (non-mem), the faulting
  // address, or zero for a legal access; a load then overwrites it with the
  // formatted response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_addr     <= '0;
      pkt_be       <= 4'h0;
      pkt_wdata    <= '0;
      pkt_we       <= 1'b0;
      pkt_f3       <= 3'b000;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      wb_data      <= '0;
      wb_fault     <= 1'b0;
    end else if (take) begin
      pkt_addr     <= ex_alu_result;
      pkt_be       <= in_be;
      pkt_wdata    <= in_wdata;
      pkt_we       <= ex_mem_write;
      pkt_f3       <= ex_funct3;
      wb_rd        <= ex_rd;
      wb_reg_write <= (in_fault || ex_mem_write) ? 1'b0 : ex_reg_write;
      wb_data      <= (in_mem && !in_fault) ? '0 : ex_alu_result;
      wb_fault     <= in_fault;
    end else if (resp && !pkt_we) begin
      wb_data      <= load_fmt;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage. The stimulus process issues EX
// packets, plays the data-memory bus and pushes the expected WB packet into a
// queue; a monitor pops and compares whenever a WB handshake happens.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        wb_fault;

  int checks   = 0;
  int failures = 0;

  // Expected WB packets, packed as {rd, reg_write, fault, data}.
  logic [38:0] sbq[$];
  logic [38:0] monExp;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_data(wb_data), .wb_fault(wb_fault)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic expectWb(input logic [4:0] rd, input logic rw, input logic fault, input logic [31:0] data);
    sbq.push_back({rd, rw, fault, data});
  endtask

  // Present one EX packet and hold it until accepted; waits counts the cycles
  // the packet sat unaccepted. Returns just after the accepting edge.
  task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                               input logic rw, input logic mr, input logic mw, input logic [2:0] f3,
                               output int waits);
    bit got;
    got           = 1'b0;
    waits         = 0;
    ex_alu_result = alu;
    ex_store_data = sd;
    ex_rd         = rd;
    ex_reg_write  = rw;
    ex_mem_read   = mr;
    ex_mem_write  = mw;
    ex_funct3     = f3;
    ex_valid      = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ex_ready) got = 1'b1;
      else          waits++;
      @(posedge clk);
      #1;
    end
    ex_valid = 1'b0;
    if (!got) checkOutput("ex_accept_timeout", 64'd0, 64'd1);
  endtask

  // Play the bus for one access that is already in REQ: hold gnt low for
  // gntWait cycles, then grant; the response comes with the grant (sameCycle)
  // or one cycle later. Request fields are checked every requesting cycle.
  task automatic serveBus(input int gntWait, input logic [31:0] rdata, input logic [31:0] expAddr,
                          input logic [3:0] expBe, input logic expWe, input logic [31:0] expWdata,
                          input bit sameCycle);
    int reqCycles;
    bit unstable;
    reqCycles = 0;
    unstable  = 1'b0;
    for (int i = 0; i < gntWait; i++) begin
      @(negedge clk);
      if (dmem_req) reqCycles++;
      if (dmem_addr !== expAddr || dmem_be !== expBe || dmem_we !== expWe || dmem_wdata !== expWdata)
        unstable = 1'b1;
      @(posedge clk);
      #1;
    end
    dmem_gnt = 1'b1;
    if (sameCycle) begin
      dmem_rvalid = 1'b1;
      dmem_rdata  = rdata;
    end
    @(negedge clk);
    if (dmem_req) reqCycles++;
    checkOutput("bus_addr", 64'(dmem_addr), 64'(expAddr));
    checkOutput("bus_be", 64'(dmem_be), 64'(expBe));
    checkOutput("bus_we", 64'(dmem_we), 64'(expWe));
    checkOutput("bus_wdata", 64'(dmem_wdata), 64'(expWdata));
    @(posedge clk);
    #1;
    dmem_gnt = 1'b0;
    if (!sameCycle) begin
      dmem_rvalid = 1'b1;
      dmem_rdata  = rdata;
      @(negedge clk);
      checkOutput("req_dropped_after_gnt", 64'(dmem_req), 64'd0);
      @(posedge clk);
      #1;
    end
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    checkOutput("req_cycles", 64'(reqCycles), 64'(gntWait + 1));
    checkOutput("req_fields_stable", 64'(unstable), 64'd0);
  endtask

  // Faulting access: no bus request, packet goes straight to WB.
  task automatic checkNoReq(input string name);
    @(negedge clk);
    checkOutput(name, 64'(dmem_req), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every WB handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && wb_valid && wb_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL wb_unexpected actual rd=%0d data=0x%0h expected no packet", wb_rd, wb_data);
      end else begin
        monExp = sbq.pop_front();
        checkOutput("wb_packet", {25'b0, wb_rd, wb_reg_write, wb_fault, wb_data}, {25'b0, monExp});
      end
    end
  end

  initial begin
    int w;
    rst           = 1'b1;
    ex_valid      = 1'b0;
    ex_alu_result = 32'h0;
    ex_store_data = 32'h0;
    ex_rd         = 5'd0;
    ex_reg_write  = 1'b0;
    ex_mem_read   = 1'b0;
    ex_mem_write  = 1'b0;
    ex_funct3     = 3'b000;
    dmem_gnt      = 1'b0;
    dmem_rvalid   = 1'b0;
    dmem_rdata    = 32'h0;
    wb_ready      = 1'b1;

    // Reset state: every output low.
    #12;
    checkOutput("rst_ex_ready", 64'(ex_ready), 64'd0);
    checkOutput("rst_bus", {dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata[25:0]}, 64'd0);
    checkOutput("rst_wb", {wb_valid, wb_reg_write, wb_fault, wb_rd, wb_data}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_ex_ready", 64'(ex_ready), 64'd1);
    @(posedge clk);
    #1;

    // ADD: one cycle to wb_valid.
    expectWb(5'd5, 1'b1, 1'b0, 32'h0000_1234);
    applyStimulus(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000, w);
    @(negedge clk);
    checkOutput("alu_latency", 64'(wb_valid), 64'd1);
    @(posedge clk);
    #1;

    // Back-to-back ALU ops at one per cycle.
    expectWb(5'd1, 1'b1, 1'b0, 32'h11);
    applyStimulus(32'h11, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 3'b000, w);
    expectWb(5'd2, 1'b1, 1'b0, 32'h22);
    applyStimulus(32'h22, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 3'b000, w);
    checkOutput("b2b_wait_2", 64'(w), 64'd0);
    expectWb(5'd3, 1'b0, 1'b0, 32'h33);
    applyStimulus(32'h33, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 3'b000, w);
    checkOutput("b2b_wait_3", 64'(w), 64'd0);

    // Loads: LB/LBU at offset 3, LH/LHU, LW.
    expectWb(5'd6, 1'b1, 1'b0, 32'hFFFF_FF80);
    applyStimulus(32'h1003, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b000, w);
    serveBus(0, 32'h80FF_FF7F, 32'h1000, 4'b1000, 1'b0, 32'h0, 1'b0);
    expectWb(5'd6, 1'b1, 1'b0, 32'h0000_0080);
    applyStimulus(32'h1003, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b100, w);
    serveBus(0, 32'h80FF_FF7F, 32'h1000, 4'b1000, 1'b0, 32'h0, 1'b1);
    expectWb(5'd12, 1'b1, 1'b0, 32'hFFFF_8001);
    applyStimulus(32'h1002, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 3'b001, w);
    serveBus(1, 32'h8001_0000, 32'h1000, 4'b1100, 1'b0, 32'h0, 1'b0);
    expectWb(5'd13, 1'b1, 1'b0, 32'h0000_F00D);
    applyStimulus(32'h1000, 32'h0, 5'd13, 1'b1, 1'b1, 1'b0, 3'b101, w);
    serveBus(0, 32'h1234_F00D, 32'h1000, 4'b0011, 1'b0, 32'h0, 1'b0);
    expectWb(5'd14, 1'b1, 1'b0, 32'hCAFE_BABE);
    applyStimulus(32'h1004, 32'h0, 5'd14, 1'b1, 1'b1, 1'b0, 3'b010, w);
    serveBus(0, 32'hCAFE_BABE, 32'h1004, 4'hF, 1'b0, 32'h0, 1'b1);

    // Stores: SH with a slow grant, SB, SW. No register write, data 0.
    expectWb(5'd7, 1'b0, 1'b0, 32'h0);
    applyStimulus(32'h2002, 32'h1234_ABCD, 5'd7, 1'b1, 1'b0, 1'b1, 3'b001, w);
    serveBus(3, 32'hDEAD_0000, 32'h2000, 4'b1100, 1'b1, 32'hABCD_ABCD, 1'b0);
    expectWb(5'd0, 1'b0, 1'b0, 32'h0);
    applyStimulus(32'h3001, 32'h0000_005A, 5'd0, 1'b0, 1'b0, 1'b1, 3'b000, w);
    serveBus(0, 32'h0, 32'h3000, 4'b0010, 1'b1, 32'h5A5A_5A5A, 1'b0);
    expectWb(5'd0, 1'b0, 1'b0, 32'h0);
    applyStimulus(32'h4000, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010, w);
    serveBus(2, 32'h0, 32'h4000, 4'hF, 1'b1, 32'hDEAD_BEEF, 1'b1);

    // Faults: misaligned LW/SW/LH, illegal load and store funct3.
    expectWb(5'd8, 1'b0, 1'b1, 32'h6);
    applyStimulus(32'h0006, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 3'b010, w);
    checkNoReq("fault_lw_no_req");
    expectWb(5'd9, 1'b0, 1'b1, 32'h40);
    applyStimulus(32'h0040, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b011, w);
    checkNoReq("fault_ld_f3_no_req");
    expectWb(5'd3, 1'b0, 1'b1, 32'h44);
    applyStimulus(32'h0044, 32'h99, 5'd3, 1'b0, 1'b0, 1'b1, 3'b011, w);
    checkNoReq("fault_st_f3_no_req");
    expectWb(5'd0, 1'b0, 1'b1, 32'h2002);
    applyStimulus(32'h2002, 32'h77, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010, w);
    checkNoReq("fault_sw_no_req");
    expectWb(5'd4, 1'b0, 1'b1, 32'h1001);
    applyStimulus(32'h1001, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b001, w);
    checkNoReq("fault_lh_no_req");

    // WB back-pressure: outputs hold, then release with a same-cycle accept.
    wb_ready = 1'b0;
    expectWb(5'd10, 1'b1, 1'b0, 32'h55AA);
    applyStimulus(32'h55AA, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0, 3'b000, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_hold", {wb_valid, ex_ready, wb_rd, wb_data}, {1'b1, 1'b0, 5'd10, 32'h55AA});
      @(posedge clk);
      #1;
    end
    wb_ready = 1'b1;
    expectWb(5'd15, 1'b1, 1'b0, 32'h77);
    applyStimulus(32'h77, 32'h0, 5'd15, 1'b1, 1'b0, 1'b0, 3'b000, w);
    checkOutput("release_same_cycle", 64'(w), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;

    // Reset while waiting for rvalid; the late response is ignored.
    applyStimulus(32'h0100, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 3'b010, w);
    dmem_gnt = 1'b1;
    @(posedge clk);
    #1;
    dmem_gnt = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_outputs", {dmem_req, wb_valid, ex_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort_idle", 64'(ex_ready), 64'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    dmem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("late_rvalid_ignored", {wb_valid, dmem_req, ex_ready}, {1'b0, 1'b0, 1'b1});
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_drained", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
